// File: rtl/find_extreme_seq_if.sv
// Operand/result bundle for find_extreme_seq: the sequencer drives the master
// side, the extreme finder sits on the slave side.
interface find_extreme_seq_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDXW  = 5
);
   logic             start;
   logic             valid;
   logic [WIDTH-1:0] Data_A;
   logic [WIDTH-1:0] Data_B;
   logic [2:0]       instruction;
   logic             one_left;
   logic             find_min;
   logic             signed_mode;
   logic [WIDTH-1:0] extreme;
   logic [IDXW-1:0]  extreme_idx;
   logic [IDXW-1:0]  beat_count;
   logic             finish;
   logic             busy;
   logic             overflow;

   modport master (
      output start, valid, Data_A, Data_B, instruction, one_left, find_min, signed_mode,
      input  extreme, extreme_idx, beat_count, finish, busy, overflow
   );

   modport slave (
      input  start, valid, Data_A, Data_B, instruction, one_left, find_min, signed_mode,
      output extreme, extreme_idx, beat_count, finish, busy, overflow
   );
endinterface

// File: rtl/find_extreme_seq.sv
// Streaming extreme finder: per-beat ALU result, running max/min (signed or
// unsigned) with index and beat count, finish pulse one cycle after the last beat.
module find_extreme_seq #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BEATS = 16,
   parameter int unsigned IDXW      = $clog2(MAX_BEATS + 1)
) (
   input logic               clk,
   input logic               rst,
   find_extreme_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [IDXW-1:0] SAT_COUNT = IDXW'(MAX_BEATS);

   state_e           state_q, state_d;
   logic             find_min_q, find_min_d;
   logic             signed_q, signed_d;
   logic             one_left_q, one_left_d;
   logic [WIDTH-1:0] extreme_q, extreme_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [IDXW-1:0]  count_q, count_d;
   logic             overflow_q, overflow_d;

   logic             accept;
   logic             saturated;
   logic [WIDTH:0]   ext_a, ext_b, diff, abs_diff;
   logic             a_gt_b;
   logic [WIDTH-1:0] result;
   logic             improve;
   logic             finish_s, busy_s;

   // start always wins over a coincident beat, so a restart never counts it
   assign accept    = (state_q == ACCUM) && bus.valid && !bus.start;
   assign saturated = (count_q == SAT_COUNT);

   // ALU: ops 101/110/111 follow the mode captured at start
   always_comb begin
      ext_a    = {signed_q & bus.Data_A[WIDTH-1], bus.Data_A};
      ext_b    = {signed_q & bus.Data_B[WIDTH-1], bus.Data_B};
      diff     = ext_a - ext_b;
      abs_diff = diff[WIDTH] ? (~diff + (WIDTH+1)'(1)) : diff;
      a_gt_b   = signed_q ? ($signed(bus.Data_A) > $signed(bus.Data_B))
                          : (bus.Data_A > bus.Data_B);
      result   = '0;
      case (bus.instruction)
         3'b000:  result = bus.Data_A + bus.Data_B;
         3'b001:  result = bus.Data_A - bus.Data_B;
         3'b010:  result = bus.Data_A & bus.Data_B;
         3'b011:  result = bus.Data_A | bus.Data_B;
         3'b100:  result = bus.Data_A ^ bus.Data_B;
         3'b101:  result = a_gt_b ? bus.Data_A : bus.Data_B;
         3'b110:  result = a_gt_b ? bus.Data_B : bus.Data_A;
         default: result = abs_diff[WIDTH-1:0];
      endcase
   end

   always_comb begin
      improve = 1'b0;
      if (find_min_q) begin
         improve = signed_q ? ($signed(result) < $signed(extreme_q)) : (result < extreme_q);
      end else begin
         improve = signed_q ? ($signed(result) > $signed(extreme_q)) : (result > extreme_q);
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            ACCUM:   if (accept && one_left_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      finish_s = 1'b0;
      busy_s   = 1'b0;
      case (state_q)
         ACCUM:   busy_s   = 1'b1;
         DONE:    finish_s = 1'b1;
         default: ;
      endcase
   end

   // Datapath; index of the current beat equals the count before it, which
   // also makes extreme_idx saturate together with beat_count.
   always_comb begin
      find_min_d = find_min_q;
      signed_d   = signed_q;
      one_left_d = one_left_q;
      extreme_d  = extreme_q;
      idx_d      = idx_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (bus.start) begin
         find_min_d = bus.find_min;
         signed_d   = bus.signed_mode;
         one_left_d = 1'b0;
         extreme_d  = '0;
         idx_d      = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (accept) begin
         // one_left arriving with a beat arms the latch for the next beat
         one_left_d = bus.one_left;
         count_d    = saturated ? count_q : count_q + IDXW'(1);
         overflow_d = overflow_q | saturated;
         if ((count_q == '0) || improve) begin
            extreme_d = result;
            idx_d     = count_q;
         end
      end else begin
         one_left_d = one_left_q | bus.one_left;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         find_min_q <= 1'b0;
         signed_q   <= 1'b0;
         one_left_q <= 1'b0;
         extreme_q  <= '0;
         idx_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         find_min_q <= find_min_d;
         signed_q   <= signed_d;
         one_left_q <= one_left_d;
         extreme_q  <= extreme_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.extreme     = extreme_q;
   assign bus.extreme_idx = idx_q;
   assign bus.beat_count  = count_q;
   assign bus.finish      = finish_s;
   assign bus.busy        = busy_s;
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_find_extreme_seq.sv
// Directed bench for find_extreme_seq: default instance (MAX_BEATS=16) plus a
// MAX_BEATS=4 instance for saturation and overflow.
module tb_find_extreme_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   fin0;
   int   fin4;

   find_extreme_seq_if #(.WIDTH(8), .IDXW(5)) bus ();
   find_extreme_seq_if #(.WIDTH(8), .IDXW(3)) bus4 ();

   find_extreme_seq #(.WIDTH(8), .MAX_BEATS(16), .IDXW(5)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   find_extreme_seq #(.WIDTH(8), .MAX_BEATS(4), .IDXW(3)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.finish === 1'b1) fin0++;
      if (bus4.finish === 1'b1) fin4++;
   end

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic       sg;
      logic [7:0] exp;
   } alu_vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_seq(input logic fmin, input logic sgn);
      bus.start = 1'b1; bus.find_min = fmin; bus.signed_mode = sgn;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ol);
      bus.valid = 1'b1; bus.Data_A = a; bus.Data_B = b; bus.instruction = op; bus.one_left = ol;
      tick();
      bus.valid = 1'b0; bus.one_left = 1'b0;
   endtask

   task automatic pulse_one_left();
      bus.one_left = 1'b1;
      tick();
      bus.one_left = 1'b0;
   endtask

   task automatic beat4(input logic [7:0] a, input logic ol);
      bus4.valid = 1'b1; bus4.Data_A = a; bus4.Data_B = 8'h00; bus4.instruction = 3'b000; bus4.one_left = ol;
      tick();
      bus4.valid = 1'b0; bus4.one_left = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++; if (bus.extreme !== 8'h00) begin errors++; $display("FAIL reset_extreme: got %h expected 00", bus.extreme); end
      checks++; if (bus.extreme_idx !== 5'd0 || bus.beat_count !== 5'd0) begin errors++; $display("FAIL reset_idx_count: got %0d/%0d expected 0/0", bus.extreme_idx, bus.beat_count); end
      checks++; if ({bus.finish, bus.busy, bus.overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.finish, bus.busy, bus.overflow}); end
      checks++; if ({bus4.finish, bus4.busy, bus4.overflow, bus4.beat_count} !== 6'b0) begin errors++; $display("FAIL reset_dut4: got %b expected 000000", {bus4.finish, bus4.busy, bus4.overflow, bus4.beat_count}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_rst_mid();
      int f0;
      f0 = fin0;
      start_seq(1'b0, 1'b0);
      beat(8'h01, 8'h00, 3'b000, 1'b0);
      beat(8'h02, 8'h00, 3'b000, 1'b1);
      checks++; if (bus.beat_count !== 5'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_before: got count %0d busy %b expected 2 1", bus.beat_count, bus.busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({bus.extreme, bus.extreme_idx, bus.beat_count, bus.finish, bus.busy, bus.overflow} !== 21'b0) begin errors++; $display("FAIL rstmid_clear: got %h/%0d/%0d/%b%b%b expected all 0", bus.extreme, bus.extreme_idx, bus.beat_count, bus.finish, bus.busy, bus.overflow); end
      beat(8'h03, 8'h00, 3'b000, 1'b0);
      tick();
      checks++; if (bus.beat_count !== 5'd0) begin errors++; $display("FAIL idle_valid_ignored: got count %0d expected 0", bus.beat_count); end
      checks++; if (fin0 != f0) begin errors++; $display("FAIL rstmid_no_finish: got %0d pulses expected 0", fin0 - f0); end
   endtask

   task automatic test_unsigned_max();
      int f0;
      f0 = fin0;
      start_seq(1'b0, 1'b0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL umax_busy: got %b expected 1", bus.busy); end
      beat(8'h10, 8'h05, 3'b000, 1'b0);
      beat(8'hF0, 8'h20, 3'b000, 1'b0);
      beat(8'h30, 8'h10, 3'b001, 1'b0);
      pulse_one_left();
      checks++; if (bus.finish !== 1'b0 || bus.beat_count !== 5'd3) begin errors++; $display("FAIL umax_pre: got finish %b count %0d expected 0 3", bus.finish, bus.beat_count); end
      beat(8'hAA, 8'h0F, 3'b010, 1'b0);
      checks++; if (bus.finish !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL umax_finish: got finish %b busy %b expected 1 0", bus.finish, bus.busy); end
      checks++; if (bus.extreme !== 8'h20) begin errors++; $display("FAIL umax_extreme: got %h expected 20", bus.extreme); end
      checks++; if (bus.extreme_idx !== 5'd2 || bus.beat_count !== 5'd4 || bus.overflow !== 1'b0) begin errors++; $display("FAIL umax_idx_count: got %0d/%0d/%b expected 2/4/0", bus.extreme_idx, bus.beat_count, bus.overflow); end
      tick();
      checks++; if (bus.finish !== 1'b0 || bus.extreme !== 8'h20 || bus.beat_count !== 5'd4) begin errors++; $display("FAIL umax_hold: got finish %b ext %h count %0d expected 0 20 4", bus.finish, bus.extreme, bus.beat_count); end
      checks++; if (fin0 - f0 != 1) begin errors++; $display("FAIL umax_pulses: got %0d expected 1", fin0 - f0); end
   endtask

   task automatic test_signed_min();
      start_seq(1'b1, 1'b1);
      beat(8'h80, 8'h01, 3'b101, 1'b0);
      beat(8'h7F, 8'h00, 3'b110, 1'b1);
      beat(8'h05, 8'hFB, 3'b111, 1'b0);
      checks++; if (bus.finish !== 1'b1 || bus.extreme !== 8'h00 || bus.extreme_idx !== 5'd1 || bus.beat_count !== 5'd3) begin errors++; $display("FAIL smin: got fin %b ext %h idx %0d cnt %0d expected 1 00 1 3", bus.finish, bus.extreme, bus.extreme_idx, bus.beat_count); end
      tick();
   endtask

   task automatic test_signed_max();
      start_seq(1'b0, 1'b1);
      beat(8'h80, 8'h00, 3'b000, 1'b0);
      beat(8'h01, 8'h00, 3'b000, 1'b0);
      beat(8'hFF, 8'h00, 3'b000, 1'b1);
      beat(8'hFE, 8'h00, 3'b000, 1'b0);
      checks++; if (bus.finish !== 1'b1 || bus.extreme !== 8'h01 || bus.extreme_idx !== 5'd1 || bus.beat_count !== 5'd4) begin errors++; $display("FAIL smax: got fin %b ext %h idx %0d cnt %0d expected 1 01 1 4", bus.finish, bus.extreme, bus.extreme_idx, bus.beat_count); end
      tick();
   endtask

   task automatic test_tie();
      start_seq(1'b0, 1'b0);
      beat(8'h40, 8'h00, 3'b000, 1'b0);
      beat(8'h20, 8'h20, 3'b000, 1'b1);
      checks++; if (bus.finish !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL tie_one_left_next: got finish %b busy %b expected 0 1", bus.finish, bus.busy); end
      beat(8'h3F, 8'h00, 3'b011, 1'b0);
      checks++; if (bus.finish !== 1'b1 || bus.extreme !== 8'h40 || bus.extreme_idx !== 5'd0 || bus.beat_count !== 5'd3) begin errors++; $display("FAIL tie: got fin %b ext %h idx %0d cnt %0d expected 1 40 0 3", bus.finish, bus.extreme, bus.extreme_idx, bus.beat_count); end
      beat(8'hFF, 8'h00, 3'b000, 1'b0);
      checks++; if (bus.beat_count !== 5'd3 || bus.extreme !== 8'h40 || bus.busy !== 1'b0) begin errors++; $display("FAIL done_valid_ignored: got cnt %0d ext %h busy %b expected 3 40 0", bus.beat_count, bus.extreme, bus.busy); end
   endtask

   task automatic test_start_abort();
      int f0;
      f0 = fin0;
      start_seq(1'b0, 1'b0);
      beat(8'h50, 8'h00, 3'b000, 1'b0);
      beat(8'h60, 8'h00, 3'b000, 1'b1);
      bus.start = 1'b1; bus.valid = 1'b1; bus.Data_A = 8'hFF; bus.Data_B = 8'h00; bus.instruction = 3'b000;
      tick();
      bus.start = 1'b0; bus.valid = 1'b0;
      checks++; if (bus.beat_count !== 5'd0 || bus.extreme !== 8'h00 || bus.busy !== 1'b1 || bus.finish !== 1'b0) begin errors++; $display("FAIL abort_restart: got cnt %0d ext %h busy %b fin %b expected 0 00 1 0", bus.beat_count, bus.extreme, bus.busy, bus.finish); end
      beat(8'h11, 8'h01, 3'b000, 1'b1);
      checks++; if (bus.finish !== 1'b0 || bus.beat_count !== 5'd1) begin errors++; $display("FAIL abort_latch_cleared: got fin %b cnt %0d expected 0 1", bus.finish, bus.beat_count); end
      beat(8'h01, 8'h01, 3'b001, 1'b0);
      checks++; if (bus.finish !== 1'b1 || bus.extreme !== 8'h12 || bus.extreme_idx !== 5'd0 || bus.beat_count !== 5'd2) begin errors++; $display("FAIL abort_new_seq: got fin %b ext %h idx %0d cnt %0d expected 1 12 0 2", bus.finish, bus.extreme, bus.extreme_idx, bus.beat_count); end
      tick();
      checks++; if (fin0 - f0 != 1) begin errors++; $display("FAIL abort_pulses: got %0d expected 1", fin0 - f0); end
   endtask

   task automatic test_alu_ops();
      alu_vec_t vecs [13];
      vecs = '{
         '{8'h10, 8'h05, 3'b000, 1'b0, 8'h15},
         '{8'h05, 8'h10, 3'b001, 1'b0, 8'hF5},
         '{8'h3C, 8'h0F, 3'b010, 1'b0, 8'h0C},
         '{8'h30, 8'h0F, 3'b011, 1'b0, 8'h3F},
         '{8'h3C, 8'h0F, 3'b100, 1'b0, 8'h33},
         '{8'h80, 8'h01, 3'b101, 1'b0, 8'h80},
         '{8'h80, 8'h01, 3'b101, 1'b1, 8'h01},
         '{8'h80, 8'h01, 3'b110, 1'b0, 8'h01},
         '{8'h80, 8'h01, 3'b110, 1'b1, 8'h80},
         '{8'h05, 8'hFB, 3'b111, 1'b0, 8'hF6},
         '{8'h05, 8'hFB, 3'b111, 1'b1, 8'h0A},
         '{8'h80, 8'h7F, 3'b111, 1'b1, 8'hFF},
         '{8'h7F, 8'h80, 3'b111, 1'b0, 8'h01}
      };
      for (int i = 0; i < 13; i++) begin
         start_seq(1'b0, vecs[i].sg);
         pulse_one_left();
         beat(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
         checks++; if (bus.finish !== 1'b1 || bus.extreme !== vecs[i].exp || bus.beat_count !== 5'd1) begin errors++; $display("FAIL alu_vec%0d: got fin %b ext %h cnt %0d expected 1 %h 1", i, bus.finish, bus.extreme, bus.beat_count, vecs[i].exp); end
         tick();
      end
   endtask

   task automatic test_overflow();
      int f4;
      f4 = fin4;
      bus4.start = 1'b1; bus4.find_min = 1'b0; bus4.signed_mode = 1'b0;
      tick();
      bus4.start = 1'b0;
      for (int i = 1; i <= 4; i++) beat4(8'(i), 1'b0);
      checks++; if (bus4.beat_count !== 3'd4 || bus4.overflow !== 1'b0 || bus4.extreme_idx !== 3'd3) begin errors++; $display("FAIL ovf_at_max: got cnt %0d ovf %b idx %0d expected 4 0 3", bus4.beat_count, bus4.overflow, bus4.extreme_idx); end
      beat4(8'h05, 1'b0);
      checks++; if (bus4.beat_count !== 3'd4 || bus4.overflow !== 1'b1 || bus4.extreme !== 8'h05 || bus4.extreme_idx !== 3'd4) begin errors++; $display("FAIL ovf_first: got cnt %0d ovf %b ext %h idx %0d expected 4 1 05 4", bus4.beat_count, bus4.overflow, bus4.extreme, bus4.extreme_idx); end
      beat4(8'h06, 1'b1);
      beat4(8'h07, 1'b0);
      checks++; if (bus4.finish !== 1'b1 || bus4.extreme !== 8'h07 || bus4.extreme_idx !== 3'd4 || bus4.beat_count !== 3'd4 || bus4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_final: got fin %b ext %h idx %0d cnt %0d ovf %b expected 1 07 4 4 1", bus4.finish, bus4.extreme, bus4.extreme_idx, bus4.beat_count, bus4.overflow); end
      tick();
      checks++; if (fin4 - f4 != 1 || bus4.overflow !== 1'b1 || bus4.finish !== 1'b0) begin errors++; $display("FAIL ovf_hold: got pulses %0d ovf %b fin %b expected 1 1 0", fin4 - f4, bus4.overflow, bus4.finish); end
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      checks++; if (bus4.overflow !== 1'b0 || bus4.beat_count !== 3'd0 || bus4.busy !== 1'b1) begin errors++; $display("FAIL ovf_restart: got ovf %b cnt %0d busy %b expected 0 0 1", bus4.overflow, bus4.beat_count, bus4.busy); end
   endtask

   initial begin
      checks = 0; errors = 0; fin0 = 0; fin4 = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.valid = 1'b0; bus.Data_A = '0; bus.Data_B = '0;
      bus.instruction = '0; bus.one_left = 1'b0; bus.find_min = 1'b0; bus.signed_mode = 1'b0;
      bus4.start = 1'b0; bus4.valid = 1'b0; bus4.Data_A = '0; bus4.Data_B = '0;
      bus4.instruction = '0; bus4.one_left = 1'b0; bus4.find_min = 1'b0; bus4.signed_mode = 1'b0;
      test_reset();
      test_rst_mid();
      test_unsigned_max();
      test_signed_min();
      test_signed_max();
      test_tie();
      test_start_abort();
      test_alu_ops();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
